mandel_sched: RTL and testbench

- Slot scheduler for the fixed-latency, non-stallable Mandelbrot FP iteration pipeline. It computes z(k+1) = z(k)^2 + c.
- Interleaves up to LAT pixels in flight. Recirculates each pixel's z through the pipeline until it escapes or reaches MAX_ITER.
- Returns (id, iteration count, escaped) over a valid/ready output. Sits between the pixel generator and the framebuffer colour-mapper.

---
 rtl/mandel_sched.sv | 182 ++++++++++++++++++
 tb/tb_mandel_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandel_sched.sv
// Slot scheduler for a fixed-latency, non-stallable Mandelbrot iteration pipeline.
// A LAT-deep shadow ring tracks which pixel owns each datapath slot and recirculates z until it finishes.
module mandel_sched #(
  parameter int LAT      = 19,
  parameter int ID_W     = 16,
  parameter int ITER_W   = 16,
  parameter int MAX_ITER = 255
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_x0,
  input  logic [31:0]                in_y0,
  input  logic [ID_W-1:0]            in_id,
  output logic [31:0]                dp_x0,
  output logic [31:0]                dp_y0,
  output logic [31:0]                dp_xn,
  output logic [31:0]                dp_yn,
  input  logic [31:0]                dp_xn1,
  input  logic [31:0]                dp_yn1,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ID_W-1:0]            out_id,
  output logic [ITER_W-1:0]          out_iter,
  output logic                       out_escaped,
  output logic [$clog2(LAT+1)-1:0]   inflight,
  output logic                       busy
);

  localparam int CNT_W = $clog2(LAT+1);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ITER_W-1:0] iter;
    logic              esc;
    logic [31:0]       x0;
    logic [31:0]       y0;
  } pay_t;

  // Ring state: control bits are reset, payload is not.
  logic [LAT-1:0]    vld_q, hold_q;
  pay_t              pay_q [LAT];

  logic [31:0]       dp_x0_q, dp_y0_q, dp_xn_q, dp_yn_q;
  logic              out_valid_q, out_esc_q;
  logic [ID_W-1:0]   out_id_q;
  logic [ITER_W-1:0] out_iter_q;
  logic [CNT_W-1:0]  inflight_q, inflight_d;

  logic              head_vld, head_hold;
  pay_t              head;
  logic              esc, done, out_free, slot_free, accept, retire;
  logic [ITER_W-1:0] iter_inc, ret_iter;
  logic              ret_esc;
  logic              iss_vld, iss_hold;
  pay_t              iss_pay;
  logic [31:0]       iss_xn, iss_yn;

  // Head decision: exactly one of CONTINUE / RETIRE / HOLD / re-HOLD, then ACCEPT or bubble into a free slot.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch can be inferred.
    head_vld  = vld_q[LAT-1];
    head_hold = hold_q[LAT-1];
    head      = pay_q[LAT-1];
    esc       = (dp_xn1[30:23] >= 8'd128) || (dp_yn1[30:23] >= 8'd128);
    iter_inc  = head.iter + 1'b1;
    out_free  = !out_valid_q || out_ready;
    done      = 1'b0;
    retire    = 1'b0;
    ret_iter  = '0;
    ret_esc   = 1'b0;
    iss_vld   = 1'b0;
    iss_hold  = 1'b0;
    iss_pay   = '0;
    iss_xn    = '0;
    iss_yn    = '0;

    if (head_vld) begin
      if (!head_hold) begin
        done = esc || (iter_inc == ITER_W'(MAX_ITER));
        if (!done) begin
          iss_vld      = 1'b1;
          iss_pay      = head;
          iss_pay.iter = iter_inc;
          iss_pay.esc  = 1'b0;
          iss_xn       = dp_xn1;
          iss_yn       = dp_yn1;
        end else if (out_free) begin
          retire   = 1'b1;
          ret_iter = iter_inc;
          ret_esc  = esc;
        end else begin
          iss_vld      = 1'b1;
          iss_hold     = 1'b1;
          iss_pay      = head;
          iss_pay.iter = iter_inc;
          iss_pay.esc  = esc;
        end
      end else if (out_free) begin
        // Held entries carry their final result; the datapath output is garbage here.
        retire   = 1'b1;
        ret_iter = head.iter;
        ret_esc  = head.esc;
      end else begin
        iss_vld  = 1'b1;
        iss_hold = 1'b1;
        iss_pay  = head;
      end
    end

    slot_free = !head_vld || retire;
    accept    = slot_free && in_valid;
    if (accept) begin
      iss_vld      = 1'b1;
      iss_hold     = 1'b0;
      iss_pay.id   = in_id;
      iss_pay.iter = '0;
      iss_pay.esc  = 1'b0;
      iss_pay.x0   = in_x0;
      iss_pay.y0   = in_y0;
      iss_xn       = '0;
      iss_yn       = '0;
    end

    inflight_d = inflight_q;
    if (accept && !retire)      inflight_d = inflight_q + 1'b1;
    else if (retire && !accept) inflight_d = inflight_q - 1'b1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      hold_q      <= '0;
      dp_x0_q     <= '0;
      dp_y0_q     <= '0;
      dp_xn_q     <= '0;
      dp_yn_q     <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_iter_q  <= '0;
      out_esc_q   <= 1'b0;
      inflight_q  <= '0;
    end else begin
      vld_q      <= {vld_q[LAT-2:0], iss_vld};
      hold_q     <= {hold_q[LAT-2:0], iss_hold};
      dp_x0_q    <= iss_pay.x0;
      dp_y0_q    <= iss_pay.y0;
      dp_xn_q    <= iss_xn;
      dp_yn_q    <= iss_yn;
      inflight_q <= inflight_d;
      // A retire in the same cycle as a drain reloads directly, leaving no bubble.
      if (retire) begin
        out_valid_q <= 1'b1;
        out_id_q    <= head.id;
        out_iter_q  <= ret_iter;
        out_esc_q   <= ret_esc;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: payload storage is deliberately left out of reset; vld_q alone decides whether it is meaningful.
  always_ff @(posedge clock) begin
    pay_q[0] <= iss_pay;
    for (int i = 1; i < LAT; i++) pay_q[i] <= pay_q[i-1];
  end

  assign in_ready    = slot_free;
  assign dp_x0       = dp_x0_q;
  assign dp_y0       = dp_y0_q;
  assign dp_xn       = dp_xn_q;
  assign dp_yn       = dp_yn_q;
  assign out_valid   = out_valid_q;
  assign out_id      = out_id_q;
  assign out_iter    = out_iter_q;
  assign out_escaped = out_esc_q;
  assign inflight    = inflight_q;
  assign busy        = (inflight_q != '0) || out_valid_q;

endmodule

// File: tb/tb_mandel_sched.sv
// Directed bench for mandel_sched with a behavioural LAT-cycle z^2+c datapath model.
// Two instances: MAX_ITER=255 for most steps, MAX_ITER=3 for the iteration-cap step.
module tb_mandel_sched;

  localparam int LAT = 19;
  localparam int CW  = $clog2(LAT+1);

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_escaped, busy;
  logic [31:0] in_x0 = '0, in_y0 = '0, dp_x0, dp_y0, dp_xn, dp_yn, dp_xn1, dp_yn1;
  logic [15:0] in_id = '0, out_id, out_iter;
  logic [CW-1:0] inflight;

  logic        in_valid_3 = 1'b0, in_ready_3, out_valid_3, out_ready_3 = 1'b1, out_escaped_3, busy_3;
  logic [31:0] in_x0_3 = '0, in_y0_3 = '0, dp_x0_3, dp_y0_3, dp_xn_3, dp_yn_3, dp_xn1_3, dp_yn1_3;
  logic [15:0] in_id_3 = '0, out_id_3, out_iter_3;
  logic [CW-1:0] inflight_3;

  mandel_sched #(.LAT(LAT), .ID_W(16), .ITER_W(16), .MAX_ITER(255)) dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x0(in_x0), .in_y0(in_y0), .in_id(in_id),
    .dp_x0(dp_x0), .dp_y0(dp_y0), .dp_xn(dp_xn), .dp_yn(dp_yn),
    .dp_xn1(dp_xn1), .dp_yn1(dp_yn1),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_iter(out_iter),
    .out_escaped(out_escaped), .inflight(inflight), .busy(busy)
  );

  mandel_sched #(.LAT(LAT), .ID_W(16), .ITER_W(16), .MAX_ITER(3)) dut3 (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid_3), .in_ready(in_ready_3),
    .in_x0(in_x0_3), .in_y0(in_y0_3), .in_id(in_id_3),
    .dp_x0(dp_x0_3), .dp_y0(dp_y0_3), .dp_xn(dp_xn_3), .dp_yn(dp_yn_3),
    .dp_xn1(dp_xn1_3), .dp_yn1(dp_yn1_3),
    .out_valid(out_valid_3), .out_ready(out_ready_3), .out_id(out_id_3), .out_iter(out_iter_3),
    .out_escaped(out_escaped_3), .inflight(inflight_3), .busy(busy_3)
  );

  // Single-precision <-> real conversion; denormals flush to zero, overflow saturates to inf.
  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:23] == 8'd0) return 0.0;
    if (b[30:23] == 8'hFF) return b[31] ? -1.0e300 : 1.0e300;
    d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          ie;
    d  = $realtobits(r);
    ie = int'(d[62:52]) - 1023 + 127;
    if (d[62:52] == 11'd0) return {d[63], 31'b0};
    if (ie >= 255) return {d[63], 8'hFF, 23'b0};
    if (ie <= 0) return {d[63], 31'b0};
    return {d[63], ie[7:0], d[51:29]};
  endfunction

  function automatic logic [63:0] dp_step(input logic [31:0] x0, y0, xn, yn);
    real rx0, ry0, rxn, ryn;
    rx0 = f2r(x0); ry0 = f2r(y0); rxn = f2r(xn); ryn = f2r(yn);
    return {r2f(rxn * rxn - ryn * ryn + rx0), r2f(2.0 * rxn * ryn + ry0)};
  endfunction

  // Datapath models: dp_* registers plus LAT-1 stages puts the result at the ring head.
  logic [63:0] pipe   [LAT-1];
  logic [63:0] pipe_3 [LAT-1];
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT-1; i++) begin
        pipe[i]   <= '0;
        pipe_3[i] <= '0;
      end
    end else begin
      pipe[0]   <= dp_step(dp_x0, dp_y0, dp_xn, dp_yn);
      pipe_3[0] <= dp_step(dp_x0_3, dp_y0_3, dp_xn_3, dp_yn_3);
      for (int i = 1; i < LAT-1; i++) begin
        pipe[i]   <= pipe[i-1];
        pipe_3[i] <= pipe_3[i-1];
      end
    end
  end
  assign dp_xn1   = pipe[LAT-2][63:32];
  assign dp_yn1   = pipe[LAT-2][31:0];
  assign dp_xn1_3 = pipe_3[LAT-2][63:32];
  assign dp_yn1_3 = pipe_3[LAT-2][31:0];

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offers one pixel to dut with out_ready=1 and checks latency and result.
  task automatic run_single(input string tag, input logic [31:0] x0, input logic [31:0] y0,
                            input logic [15:0] id, input int exp_lat,
                            input logic [15:0] exp_iter, input logic exp_esc);
    int cnt;
    in_x0 = x0; in_y0 = y0; in_id = id; in_valid = 1'b1;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check({tag, ".dp_x0"}, dp_x0, x0);
    check({tag, ".inflight"}, 32'(inflight), 32'd1);
    cnt = 1;
    while (!out_valid && cnt < exp_lat + 50) begin
      tick();
      cnt++;
    end
    check({tag, ".latency"}, 32'(cnt), 32'(exp_lat));
    check({tag, ".out_id"}, 32'(out_id), 32'(id));
    check({tag, ".out_iter"}, 32'(out_iter), 32'(exp_iter));
    check({tag, ".out_escaped"}, 32'(out_escaped), 32'(exp_esc));
    tick();
    check({tag, ".drained"}, 32'(out_valid), 32'd0);
    check({tag, ".inflight_end"}, 32'(inflight), 32'd0);
    check({tag, ".busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt, accepted, not_ready, got, dup, bad, stale;
    logic [LAT-1:0] seen;

    // Reset state
    #2;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.inflight", 32'(inflight), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.dp_x0", dp_x0, 32'd0);
    check("rst.out_id", 32'(out_id), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd1);

    // Single pixels: escape at 1, escape at 2, capped at 255
    run_single("c2", 32'h4000_0000, 32'd0, 16'd5, LAT + 1, 16'd1, 1'b1);
    run_single("c1", 32'h3F80_0000, 32'd0, 16'd7, 2 * LAT + 1, 16'd2, 1'b1);
    run_single("cm1", 32'hBF80_0000, 32'd0, 16'd9, 255 * LAT + 1, 16'd255, 1'b0);

    // Iteration cap of 3 on the second instance
    in_x0_3 = '0; in_y0_3 = '0; in_id_3 = 16'd3; in_valid_3 = 1'b1;
    tick();
    in_valid_3 = 1'b0;
    cnt = 1;
    while (!out_valid_3 && cnt < 3 * LAT + 50) begin
      tick();
      cnt++;
    end
    check("max3.latency", 32'(cnt), 32'(3 * LAT + 1));
    check("max3.out_iter", 32'(out_iter_3), 32'd3);
    check("max3.out_escaped", 32'(out_escaped_3), 32'd0);
    check("max3.out_id", 32'(out_id_3), 32'd3);
    tick();
    check("max3.inflight", 32'(inflight_3), 32'd0);
    check("max3.busy", 32'(busy_3), 32'd0);

    // Ring fill: LAT+5 cycles of c=0 offered, only LAT accepted
    in_x0 = '0; in_y0 = '0; in_valid = 1'b1;
    accepted = 0;
    not_ready = 0;
    for (int k = 0; k < LAT + 5; k++) begin
      in_id = 16'(100 + accepted);
      #1;
      if (k < LAT) begin
        if (!in_ready) not_ready++;
      end else begin
        check($sformatf("fill.in_ready_low%0d", k), 32'(in_ready), 32'd0);
      end
      if (in_ready) accepted++;
      tick();
    end
    in_valid = 1'b0;
    check("fill.early_not_ready", 32'(not_ready), 32'd0);
    check("fill.accepted", 32'(accepted), 32'(LAT));
    check("fill.inflight", 32'(inflight), 32'(LAT));

    #3 rst_n = 1'b0;
    #1;
    check("fill.rst_inflight", 32'(inflight), 32'd0);
    check("fill.rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;

    // Back-pressure: LAT escaping pixels with out_ready low
    out_ready = 1'b0;
    in_x0 = 32'h4000_0000; in_y0 = '0; in_valid = 1'b1;
    not_ready = 0;
    for (int k = 0; k < LAT; k++) begin
      in_id = 16'(200 + k);
      #1;
      if (!in_ready) not_ready++;
      tick();
    end
    in_valid = 1'b0;
    check("hold.accept_all", 32'(not_ready), 32'd0);
    repeat (2 * LAT) tick();
    check("hold.out_valid", 32'(out_valid), 32'd1);
    check("hold.out_id_first", 32'(out_id), 32'd200);
    check("hold.out_iter", 32'(out_iter), 32'd1);
    check("hold.inflight", 32'(inflight), 32'(LAT - 1));
    out_ready = 1'b1;
    seen = '0; got = 0; dup = 0; bad = 0;
    for (int c = 0; c < 4 * LAT; c++) begin
      if (out_valid) begin
        if (out_id < 16'd200 || out_id >= 16'(200 + LAT)) bad++;
        else if (seen[out_id - 16'd200]) dup++;
        else seen[out_id - 16'd200] = 1'b1;
        if (out_iter != 16'd1 || !out_escaped) bad++;
        got++;
      end
      tick();
    end
    check("hold.delivered", 32'(got), 32'(LAT));
    check("hold.duplicates", 32'(dup), 32'd0);
    check("hold.bad_results", 32'(bad), 32'd0);
    check("hold.all_ids", 32'(seen), 32'((1 << LAT) - 1));
    check("hold.busy_end", 32'(busy), 32'd0);

    // Mid-run reset with a held result and 10 pixels in flight
    out_ready = 1'b0;
    in_x0 = 32'h4000_0000; in_y0 = '0; in_id = 16'd50; in_valid = 1'b1;
    tick();
    in_x0 = '0;
    for (int k = 0; k < 10; k++) begin
      in_id = 16'(60 + k);
      tick();
    end
    in_valid = 1'b0;
    repeat (LAT) tick();
    check("mrst.pre_out_valid", 32'(out_valid), 32'd1);
    check("mrst.pre_out_id", 32'(out_id), 32'd50);
    check("mrst.pre_inflight", 32'(inflight), 32'd10);
    #3 rst_n = 1'b0;
    #1;
    check("mrst.out_valid", 32'(out_valid), 32'd0);
    check("mrst.inflight", 32'(inflight), 32'd0);
    check("mrst.busy", 32'(busy), 32'd0);
    check("mrst.out_id", 32'(out_id), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mrst.in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    run_single("post_rst", 32'h4000_0000, 32'd0, 16'd77, LAT + 1, 16'd1, 1'b1);
    stale = 0;
    for (int c = 0; c < 3 * LAT; c++) begin
      if (out_valid) stale++;
      tick();
    end
    check("mrst.no_stale", 32'(stale), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
